// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq
// Operand / effective-address fetch sequencer. Once started, it pulls
// 1..BYTES bytes from the PC stream, most significant byte first, and
// assembles them into ea. It honours the memory ready handshake and can be
// cancelled with abort.
//
// Ports
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start, mode  : begin a sequence; mode 0=direct 1=extended 2=imm8 3=imm-wide
//   abort        : synchronous cancel of an in-flight sequence
//   dp           : direct-page register, the high byte of a direct address
//   mem_data     : read data from the PC-addressed fetch
//   mem_ready    : mem_data is valid this cycle
//   active       : sequencer is busy (not IDLE)
//   mem_read_pc  : request a read at PC
//   pc_inc       : advance PC (a byte was accepted)
//   ar_fetch     : one-hot field select, bit BYTES-1-k while fetching byte k
//   ea, is_imm   : assembled address/operand, and flag marking immediate data
//   done         : one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | requesting/accepting bytes from the PC stream
// DONE   | ea complete, done pulsed for one cycle
module operand_fetch_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16   // integer multiple of DATA_W, at least 2x
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic                               abort,
  input  logic [DATA_W-1:0]                  dp,
  input  logic [DATA_W-1:0]                  mem_data,
  input  logic                               mem_ready,
  output logic                               active,
  output logic                               mem_read_pc,
  output logic                               pc_inc,
  output logic [(ADDR_W/DATA_W)-1:0]         ar_fetch,
  output logic [ADDR_W-1:0]                  ea,
  output logic                               is_imm,
  output logic                               done
);

  localparam int BYTES = ADDR_W / DATA_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_DIRECT = 2'd0;
  localparam logic [1:0] M_EXT    = 2'd1;
  localparam logic [1:0] M_IMM8   = 2'd2;
  localparam logic [1:0] M_IMMW   = 2'd3;

  localparam logic [CNT_W-1:0] K_LAST_FULL = CNT_W'(BYTES - 1);
  localparam logic [BYTES-1:0] FIELD_MSB   = {1'b1, {(BYTES-1){1'b0}}};

  logic [1:0]        state_q;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  last_q;
  logic [ADDR_W-1:0] ea_q;
  logic              is_imm_q;
  logic [ADDR_W-1:0] ea_next;
  logic              accept;

  // abort wins over mem_ready, so an aborted cycle never advances PC
  assign accept = (state_q == S_FETCH) && mem_ready && !abort;

  // direct mode replaces ea with {dp, byte}; every other mode shifts the new
  // byte in at the bottom, which zero-extends imm8 because ea starts at 0
  always_comb begin
    ea_next = '0;
    if (mode_q == M_DIRECT) begin
      ea_next[2*DATA_W-1:0] = {dp, mem_data};
    end else begin
      ea_next = {ea_q[ADDR_W-DATA_W-1:0], mem_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= M_DIRECT;
      idx_q    <= '0;
      last_q   <= '0;
      ea_q     <= '0;
      is_imm_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q  <= S_FETCH;
            mode_q   <= mode;
            idx_q    <= '0;
            last_q   <= ((mode == M_EXT) || (mode == M_IMMW)) ? K_LAST_FULL : '0;
            ea_q     <= '0;
            is_imm_q <= (mode == M_IMM8) || (mode == M_IMMW);
          end
        end
        S_FETCH: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (mem_ready) begin
            ea_q  <= ea_next;
            idx_q <= idx_q + CNT_W'(1);
            if (idx_q == last_q) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign active      = (state_q != S_IDLE);
  assign mem_read_pc = (state_q == S_FETCH);
  assign pc_inc      = accept;
  assign ar_fetch    = (state_q == S_FETCH) ? (FIELD_MSB >> idx_q) : '0;
  assign ea          = ea_q;
  assign is_imm      = is_imm_q;
  assign done        = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq: a 16-bit instance for the main sequences and a
// 24-bit instance for the three-byte extended fetch. Stimulus pushes expected
// results into queues; monitors pop and compare when the DUT shows pc_inc/done.
module tb_operand_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, mem_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] dp = 8'h00, mem_data = 8'h00;
  logic       active, mem_read_pc, pc_inc, is_imm, done;
  logic [1:0] ar_fetch;
  logic [15:0] ea;

  logic       start_b = 1'b0, abort_b = 1'b0, mem_ready_b = 1'b0;
  logic [1:0] mode_b = 2'd0;
  logic [7:0] dp_b = 8'h00, mem_data_b = 8'h00;
  logic       active_b, mem_read_pc_b, pc_inc_b, is_imm_b, done_b;
  logic [2:0] ar_fetch_b;
  logic [23:0] ea_b;

  operand_fetch_seq #(.DATA_W(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .dp(dp), .mem_data(mem_data), .mem_ready(mem_ready), .active(active),
    .mem_read_pc(mem_read_pc), .pc_inc(pc_inc), .ar_fetch(ar_fetch),
    .ea(ea), .is_imm(is_imm), .done(done)
  );

  operand_fetch_seq #(.DATA_W(8), .ADDR_W(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .abort(abort_b),
    .dp(dp_b), .mem_data(mem_data_b), .mem_ready(mem_ready_b), .active(active_b),
    .mem_read_pc(mem_read_pc_b), .pc_inc(pc_inc_b), .ar_fetch(ar_fetch_b),
    .ea(ea_b), .is_imm(is_imm_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, pcinc_cnt = 0, pcinc_exp = 0;

  typedef struct {
    logic [23:0] ea;
    logic        imm;
    int          cyc;
  } exp_t;

  exp_t        done_q[$];
  logic [1:0]  fetch_q[$];
  logic [23:0] ea24_q[$];
  logic [2:0]  ar24_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pc_inc) begin
      pcinc_cnt++;
      if (fetch_q.size() == 0) chk("pc_inc_unexpected", {31'b0, pc_inc}, 32'd0);
      else chk("ar_fetch", {30'b0, ar_fetch}, {30'b0, fetch_q.pop_front()});
    end
    if (rst_n && done) begin
      if (done_q.size() == 0) chk("done_unexpected", {31'b0, done}, 32'd0);
      else begin
        e = done_q.pop_front();
        chk("ea", {16'b0, ea}, {8'b0, e.ea});
        chk("is_imm", {31'b0, is_imm}, {31'b0, e.imm});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pc_inc_b) begin
      if (ar24_q.size() == 0) chk("b_pc_inc_unexpected", {31'b0, pc_inc_b}, 32'd0);
      else chk("b_ar_fetch", {29'b0, ar_fetch_b}, {29'b0, ar24_q.pop_front()});
    end
    if (rst_n && done_b) begin
      if (ea24_q.size() == 0) chk("b_done_unexpected", {31'b0, done_b}, 32'd0);
      else chk("b_ea", {8'b0, ea_b}, {8'b0, ea24_q.pop_front()});
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((done_q.size() + fetch_q.size() + ea24_q.size() + ar24_q.size()) != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk(name, done_q.size() + fetch_q.size() + ea24_q.size() + ar24_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // lat: cycles from the start cycle to the done cycle (hand computed)
  task automatic run_op(input logic [1:0] m, input logic [7:0] dpv, input logic [7:0] d0,
                        input logic [7:0] d1, input int nb, input int stall, input int lat,
                        input logic [15:0] exp_ea, input logic exp_imm, input logic hold_start);
    int s;
    mode = m; dp = dpv; start = 1'b1; s = cyc;
    done_q.push_back('{{8'h00, exp_ea}, exp_imm, s + lat});
    fetch_q.push_back(2'b10);
    if (nb == 2) fetch_q.push_back(2'b01);
    pcinc_exp += nb;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_read", {31'b0, mem_read_pc}, 32'd1);
      chk("stall_no_inc", {31'b0, pc_inc}, 32'd0);
      @(posedge clk); #1;
    end
    mem_data = d0; mem_ready = 1'b1;
    @(posedge clk); #1;
    if (nb == 2) begin
      mem_data = d1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    if (hold_start) begin
      start = 1'b1; mode = 2'd1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("no_restart_from_done", {31'b0, active}, 32'd0);
      @(posedge clk); #1;
    end
    wait_drain("op_timeout");
  endtask

  initial begin
    #12;
    chk("rst_ea", {16'b0, ea}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_is_imm", {31'b0, is_imm}, 32'd0);
    chk("rst_read", {31'b0, mem_read_pc}, 32'd0);
    chk("rst_ar_fetch", {30'b0, ar_fetch}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd1, 8'h00, 8'h12, 8'h34, 2, 0, 3, 16'h1234, 1'b0, 1'b0);
    run_op(2'd0, 8'hA5, 8'h3C, 8'h00, 1, 0, 2, 16'hA53C, 1'b0, 1'b0);
    run_op(2'd2, 8'h00, 8'h7F, 8'h00, 1, 0, 2, 16'h007F, 1'b1, 1'b0);
    run_op(2'd3, 8'h00, 8'hBE, 8'hEF, 2, 0, 3, 16'hBEEF, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("ea_hold", {16'b0, ea}, 32'h0000BEEF);
    chk("imm_hold", {31'b0, is_imm}, 32'd1);
    run_op(2'd1, 8'h00, 8'h56, 8'h78, 2, 3, 6, 16'h5678, 1'b0, 1'b0);

    // abort while byte 1 is offered with mem_ready high
    mode = 2'd1; start = 1'b1;
    fetch_q.push_back(2'b10); pcinc_exp += 1;
    @(posedge clk); #1; start = 1'b0; mem_data = 8'h9A; mem_ready = 1'b1;
    @(posedge clk); #1; mem_data = 8'hBC; abort = 1'b1;
    @(negedge clk);
    chk("abort_no_inc", {31'b0, pc_inc}, 32'd0);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1; abort = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_idle", {31'b0, active}, 32'd0);
    chk("abort_partial_ea", {16'b0, ea}, 32'h0000009A);
    @(posedge clk); #1;
    wait_drain("abort_timeout");

    run_op(2'd1, 8'h00, 8'hCA, 8'hFE, 2, 0, 3, 16'hCAFE, 1'b0, 1'b1);

    // reset mid-FETCH of an imm-wide operand
    mode = 2'd3; start = 1'b1;
    fetch_q.push_back(2'b10); pcinc_exp += 1;
    @(posedge clk); #1; start = 1'b0; mem_data = 8'hAB; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_ea", {16'b0, ea}, 32'h000000AB);
    chk("pre_reset_imm", {31'b0, is_imm}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_ea", {16'b0, ea}, 32'd0);
    chk("mid_reset_active", {31'b0, active}, 32'd0);
    chk("mid_reset_imm", {31'b0, is_imm}, 32'd0);
    chk("mid_reset_read", {31'b0, mem_read_pc}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    wait_drain("reset_timeout");

    // 24-bit extended fetch of 01 02 03
    mode_b = 2'd1; start_b = 1'b1;
    ar24_q.push_back(3'b100); ar24_q.push_back(3'b010); ar24_q.push_back(3'b001);
    ea24_q.push_back(24'h010203);
    @(posedge clk); #1; start_b = 1'b0; mem_ready_b = 1'b1; mem_data_b = 8'h01;
    @(posedge clk); #1; mem_data_b = 8'h02;
    @(posedge clk); #1; mem_data_b = 8'h03;
    @(posedge clk); #1; mem_ready_b = 1'b0;
    wait_drain("b_timeout");

    chk("pc_inc_total", pcinc_cnt, pcinc_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
